serial_add_seq: RTL and testbench

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/full_adder.sv | 13 +
 rtl/serial_add_seq.sv | 110 +++++++++++
 tb/tb_serial_add_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the single arithmetic element of the serial adder.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_c;
  assign o_cout = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: computes a + b + cin one bit per clock, LSB first.
// Sequence per operation: IDLE (accept) -> RUN for WIDTH cycles -> DONE -> IDLE.
// Operands are captured only on the accepting edge; start is ignored outside IDLE.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_shifted;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_cout;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_cnt == LAST_BIT);

  // The only arithmetic: operand LSBs plus the running carry.
  full_adder u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_c    (r_carry),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  // State register; reset aborts any in-flight addition without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: DONE always lasts one cycle and returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Shift the new sum bit into the MSB; after WIDTH shifts bit 0 lands at LSB.
  // Written as shift-then-overwrite so WIDTH=1 needs no special case.
  always_comb begin
    w_sum_shifted            = r_sum >> 1;
    w_sum_shifted[WIDTH-1]   = w_fa_sum;
  end

  // Datapath: load on accept, one bit per RUN cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_fa_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      r_sum   <= w_sum_shifted;
      if (w_last) begin
        r_cout <= w_fa_cout;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq at WIDTH=8: directed vector table,
// hand-written multi-cycle corner cases and a long back-to-back random run.
module tb_serial_add_seq;

  localparam int W = 8;
  localparam int MAX_EDGES = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  // busy and done never together; done never two cycles in a row.
  logic mon_prev_done = 1'b0;
  always @(negedge clk) begin
    total++;
    if ((busy === 1'b1 && done === 1'b1) || (done === 1'b1 && mon_prev_done === 1'b1)) begin
      bad++;
      $display("FAIL monitor: busy=%b done=%b prev_done=%b", busy, done, mon_prev_done);
    end
    mon_prev_done = done;
  end

  // Drive start with operands just after an edge; the next edge accepts.
  // edges counts clock edges from that point until done is observed, so the
  // accepting edge is edge 1 and done is expected on edge W+1.
  // Operands are scrambled after the accept edge; they must not matter.
  task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        output logic [W-1:0] s, output logic co, output int edges);
    start = 1'b1; a = ta; b = tb_v; cin = tc;
    @(posedge clk); #1;
    edges = 1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    while (done !== 1'b1 && edges < MAX_EDGES) begin
      @(posedge clk); #1;
      edges++;
    end
    s  = sum;
    co = cout;
  endtask

  // Watch n edges and report whether any done pulse appeared.
  task automatic watch_no_done(input int n, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    logic [W-1:0] s;
    logic         co;
    int           edges;
    logic         seen;
    logic         prev_cout;
    logic [W:0]   ref_v;
    logic [W-1:0] ra, rb;
    logic         rc;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'h55, 8'hAB, 1'b0, 8'h00, 1'b1};

    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum",  32'(sum),  32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, edges);
      $display("vec %0d: %02h+%02h+%0d -> sum=%02h cout=%0d edges=%0d", i, vecs[i].a, vecs[i].b,
               vecs[i].cin, s, co, edges);
      check($sformatf("vec%0d_latency", i), 32'(edges), 32'(W + 1));
      check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].exp_cout));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_drop", i), 32'(done), 32'd0);
      check($sformatf("vec%0d_sum_hold", i), 32'(sum), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout_hold", i), 32'(cout), 32'(vecs[i].exp_cout));
    end

    // Chained: carry out of the low byte feeds the high byte.
    do_add(8'h80, 8'h80, 1'b0, s, co, edges);
    $display("chain lo: 80+80+0 -> sum=%02h cout=%0d", s, co);
    check("chain_lo_sum", 32'(s), 32'h00);
    check("chain_lo_cout", 32'(co), 32'd1);
    prev_cout = co;
    @(posedge clk); #1;
    do_add(8'h01, 8'h00, prev_cout, s, co, edges);
    $display("chain hi: 01+00+%0d -> sum=%02h cout=%0d", prev_cout, s, co);
    check("chain_hi_sum", 32'(s), 32'h02);
    check("chain_hi_cout", 32'(co), 32'd0);
    @(posedge clk); #1;

    // start pulsed with new operands during RUN must be ignored.
    start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
    @(posedge clk); #1;
    edges = 1;
    start = 1'b0; a = 8'h00; b = 8'h00;
    check("run_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 2; k++) begin @(posedge clk); #1; edges++; end
    start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
    for (int k = 0; k < 2; k++) begin @(posedge clk); #1; edges++; end
    start = 1'b0;
    while (done !== 1'b1 && edges < MAX_EDGES) begin @(posedge clk); #1; edges++; end
    $display("ignore start: 0F+01+0 -> sum=%02h cout=%0d edges=%0d", sum, cout, edges);
    check("ignore_latency", 32'(edges), 32'(W + 1));
    check("ignore_sum", 32'(sum), 32'h10);
    check("ignore_cout", 32'(cout), 32'd0);
    watch_no_done(12, seen);
    check("ignore_no_second_done", 32'(seen), 32'd0);

    // Reset during the 4th RUN cycle aborts without a done pulse.
    start = 1'b1; a = 8'hFF; b = 8'h00; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
    check("abort_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("abort: busy=%0d done=%0d sum=%02h cout=%0d", busy, done, sum, cout);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    watch_no_done(12, seen);
    check("abort_no_done", 32'(seen), 32'd0);
    do_add(8'h03, 8'h04, 1'b0, s, co, edges);
    $display("after abort: 03+04+0 -> sum=%02h cout=%0d", s, co);
    check("post_abort_sum", 32'(s), 32'h07);
    check("post_abort_cout", 32'(co), 32'd0);
    check("post_abort_latency", 32'(edges), 32'(W + 1));
    @(posedge clk); #1;

    // Random, start held high: accepts back-to-back every W+2 cycles.
    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
    start = 1'b1; a = ra; b = rb; cin = rc;
    for (int i = 0; i < 1000; i++) begin
      edges = 0;
      do begin
        @(posedge clk); #1;
        edges++;
      end while (done !== 1'b1 && edges < MAX_EDGES);
      ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      if (i < 4 || i % 100 == 0)
        $display("rand %0d: %02h+%02h+%0d -> sum=%02h cout=%0d edges=%0d", i, ra, rb, rc, sum, cout, edges);
      check($sformatf("rand%0d_sum", i), 32'(sum), 32'(ref_v[W-1:0]));
      check($sformatf("rand%0d_cout", i), 32'(cout), 32'(ref_v[W]));
      check($sformatf("rand%0d_period", i), 32'(edges), (i == 0) ? 32'(W + 1) : 32'(W + 2));
      if (edges >= MAX_EDGES) break;
      // Still in DONE here; the next accept happens two edges later.
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      a = ra; b = rb; cin = rc;
    end
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
